// File: rtl/even_parity_generator_3bit.sv
// even_parity_generator_3bit
//
// Registered 3-bit even-parity generator with enable. When E is high, the block
// computes P so that the codeword {A, P} has an even number of ones. It registers
// P and the 4-bit codeword Y on the next rising edge. When E is low, or while rst
// is high, both outputs are a clean zero.
//
// Ports:
//   clk  in   1  System clock. All state changes on the rising edge.
//   rst  in   1  Synchronous active-high reset.
//   A    in   3  Data word to protect.
//   E    in   1  Enable. 1 = generate parity, 0 = force outputs to zero.
//   P    out  1  Registered even-parity bit.
//   Y    out  4  Registered codeword {A, P}. A is in Y[3:1] and P is in Y[0].
//
// Latency is one cycle and throughput is one word per cycle. P and Y come
// straight from flops, so no input reaches an output through logic alone.

module even_parity_generator_3bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic       E,
  output logic       P,
  output logic [3:0] Y
);

  logic       p_d, p_q;
  logic [3:0] y_d, y_q;

  // Next-state logic. When disabled, A is not used at all.
  // An X on A therefore cannot leak into the outputs while E is low.
  always_comb begin
    p_d = 1'b0;
    y_d = 4'b0000;
    if (E) begin
      p_d = ^A;
      y_d = {A, p_d};
    end
  end

  // Reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= 1'b0;
      y_q <= 4'b0000;
    end else begin
      p_q <= p_d;
      y_q <= y_d;
    end
  end

  assign P = p_q;
  assign Y = y_q;

endmodule

// File: tb/tb_even_parity_generator_3bit.sv
module tb_even_parity_generator_3bit;

  logic       clk;
  logic       rst;
  logic [2:0] A;
  logic       E;
  logic       P;
  logic [3:0] Y;

  even_parity_generator_3bit dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .E   (E),
    .P   (P),
    .Y   (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       e;
    logic [2:0] a;
    logic       exp_p;
    logic [3:0] exp_y;
    string      name;
  } vec_t;

  typedef struct {
    logic       p;
    logic [3:0] y;
    logic       en;
    logic [2:0] a;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;
  vec_t vecs[28];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus and push its expectation. Sample 1 ns after the
  // edge, then pop the expectation and compare it.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = v.rst;
    E   = v.e;
    A   = v.a;
    e.p = v.exp_p;
    e.y = v.exp_y;
    e.en = !v.rst && v.e;
    e.a = v.a;
    e.name = v.name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", v.name);
    end else begin
      got = sb_q.pop_front();
      check({got.name, ".P"}, {3'b000, P}, {3'b000, got.p});
      check({got.name, ".Y"}, Y, got.y);
      if (got.en) begin
        // Even popcount invariant, and P equals the parity of the A that was sampled.
        check({got.name, ".popcnt_odd"}, {3'b000, ^Y}, 4'b0000);
        check({got.name, ".p_vs_prev_a"}, {3'b000, P},
              {3'b000, got.a[2] ^ got.a[1] ^ got.a[0]});
      end
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] a,
                              input logic p, input logic [3:0] y, input string name);
    vec_t v;
    v.rst = r; v.e = e; v.a = a; v.exp_p = p; v.exp_y = y; v.name = name;
    return v;
  endfunction

  initial begin
    logic [7:0] par_seq;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    E   = 1'b1;
    A   = 3'b111;
    par_seq = 8'b1001_0110; // bit i = expected P for A = i

    // Reset held for two cycles with E = 1 and A = 111.
    vecs[0] = mk(1'b1, 1'b1, 3'b111, 1'b0, 4'b0000, "reset0");
    vecs[1] = mk(1'b1, 1'b1, 3'b111, 1'b0, 4'b0000, "reset1");
    // Enabled sweep. The expected P sequence is 0,1,1,0,1,0,0,1.
    for (int i = 0; i < 8; i++) begin
      vecs[2 + i] = mk(1'b0, 1'b1, 3'(i), par_seq[i], {3'(i), par_seq[i]},
                       $sformatf("en_a%0d", i));
    end
    // Disabled sweep. The outputs must stay zero.
    for (int i = 0; i < 8; i++) begin
      vecs[10 + i] = mk(1'b0, 1'b0, 3'(i), 1'b0, 4'b0000, $sformatf("dis_a%0d", i));
    end
    // Enable toggle with A = 001.
    vecs[18] = mk(1'b0, 1'b1, 3'b001, 1'b1, 4'b0011, "tog0");
    vecs[19] = mk(1'b0, 1'b0, 3'b001, 1'b0, 4'b0000, "tog1");
    vecs[20] = mk(1'b0, 1'b1, 3'b001, 1'b1, 4'b0011, "tog2");
    // Mid-stream reset with A = 111 and E = 1.
    vecs[21] = mk(1'b0, 1'b1, 3'b111, 1'b1, 4'b1111, "mrst0");
    vecs[22] = mk(1'b1, 1'b1, 3'b111, 1'b0, 4'b0000, "mrst1");
    vecs[23] = mk(1'b0, 1'b1, 3'b111, 1'b1, 4'b1111, "mrst2");
    // Back-to-back changes, including E going 0->1 on a fresh A.
    vecs[24] = mk(1'b0, 1'b1, 3'b101, 1'b0, 4'b1010, "b2b0");
    vecs[25] = mk(1'b0, 1'b1, 3'b010, 1'b1, 4'b0101, "b2b1");
    vecs[26] = mk(1'b0, 1'b0, 3'b110, 1'b0, 4'b0000, "b2b2");
    vecs[27] = mk(1'b0, 1'b1, 3'b100, 1'b1, 4'b1001, "b2b3");

    for (int i = 0; i < 28; i++) apply(vecs[i]);

    // Hand-written sequence: X on A is ignored while disabled or held in reset.
    @(negedge clk);
    rst = 1'b0; E = 1'b0; A = 3'bxxx;
    @(posedge clk); #1;
    check("x_dis.Y", Y, 4'b0000);
    check("x_dis.P", {3'b000, P}, 4'b0000);
    @(negedge clk);
    rst = 1'b1; E = 1'b1; A = 3'bx1x;
    @(posedge clk); #1;
    check("x_rst.Y", Y, 4'b0000);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
